// File: rtl/ode_pkg.sv
// Shared definitions for the ODE integration stages: word geometry,
// the fixed-point unit constant and the Euler stage FSM encoding.
package ode_pkg;

    localparam int WORD_SIZE     = 16;
    localparam int ADDRESS_WIDTH = 4;
    localparam int FRAC_BITS     = 7;

    localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1) << FRAC_BITS;

    typedef enum logic [2:0] {
        IDLE,
        RD_X,
        RD_DX,
        MUL_REQ,
        MUL_WAIT,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/fxp_sat_adder.sv
// Combinational signed fixed-point adder with overflow flag.
// SATURATE_EN clamps overflowed sums to the signed range; otherwise wraps.
module fxp_sat_adder
    import ode_pkg::*;
#(
    parameter int WIDTH = WORD_SIZE
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [WIDTH-1:0] raw;

    assign raw = a + b;

    // Same-sign operands whose result flips sign have left the range.
    assign overflow = (a[WIDTH-1] == b[WIDTH-1])
                   && (raw[WIDTH-1] != a[WIDTH-1]);

`ifdef SATURATE_EN
    always_comb begin
        sum = raw;
        if (overflow) begin
            if (a[WIDTH-1]) begin
                sum = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                sum = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/euler_update_stage.sv
// Explicit Euler update x_out[i] = x[i] + h*dx[i] over scratch memory.
// Add overflow clamps when SATURATE_EN is defined, wraps otherwise.
module euler_update_stage #(
    parameter int WORD_SIZE     = ode_pkg::WORD_SIZE,
    parameter int ADDRESS_WIDTH = ode_pkg::ADDRESS_WIDTH,
    parameter int FRAC_BITS     = ode_pkg::FRAC_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WORD_SIZE-1:0]     n,
    input  logic [WORD_SIZE-1:0]     step,
    input  logic [ADDRESS_WIDTH-1:0] x_base,
    input  logic [ADDRESS_WIDTH-1:0] dx_base,
    input  logic [ADDRESS_WIDTH-1:0] out_base,
    output logic [ADDRESS_WIDTH-1:0] mem_rd_addr,
    input  logic [WORD_SIZE-1:0]     mem_rd_data,
    output logic                     mem_wr_en,
    output logic [ADDRESS_WIDTH-1:0] mem_wr_addr,
    output logic [WORD_SIZE-1:0]     mem_wr_data,
    output logic                     mul_start,
    output logic [WORD_SIZE-1:0]     mul_op1,
    output logic [WORD_SIZE-1:0]     mul_op2,
    input  logic [WORD_SIZE-1:0]     mul_result,
    input  logic                     mul_done,
    input  logic                     mul_overflow,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    import ode_pkg::*;

    state_t state;
    state_t state_nx;

    logic [WORD_SIZE-1:0]     n_reg;
    logic [WORD_SIZE-1:0]     h_reg;
    logic [WORD_SIZE-1:0]     i_reg;
    logic [WORD_SIZE-1:0]     x_reg;
    logic [WORD_SIZE-1:0]     prod_reg;
    logic [ADDRESS_WIDTH-1:0] x_base_reg;
    logic [ADDRESS_WIDTH-1:0] dx_base_reg;
    logic [ADDRESS_WIDTH-1:0] out_base_reg;
    logic                     ovf_reg;

    logic [WORD_SIZE-1:0]     sum;
    logic                     add_ovf;
    logic [ADDRESS_WIDTH-1:0] idx;
    logic                     last;

    assign idx      = i_reg[ADDRESS_WIDTH-1:0];
    assign last     = (i_reg + WORD_SIZE'(1)) == n_reg;
    assign overflow = ovf_reg;

    fxp_sat_adder #(
        .WIDTH (WORD_SIZE)
    ) u_add (
        .a        (x_reg),
        .b        (prod_reg),
        .sum      (sum),
        .overflow (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            n_reg        <= '0;
            h_reg        <= '0;
            i_reg        <= '0;
            x_reg        <= '0;
            prod_reg     <= '0;
            x_base_reg   <= '0;
            dx_base_reg  <= '0;
            out_base_reg <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        n_reg        <= n;
                        h_reg        <= step;
                        x_base_reg   <= x_base;
                        dx_base_reg  <= dx_base;
                        out_base_reg <= out_base;
                        i_reg        <= '0;
                        ovf_reg      <= 1'b0;
                    end
                end
                RD_DX: begin
                    x_reg <= mem_rd_data;
                end
                MUL_WAIT: begin
                    if (mul_done) begin
                        prod_reg <= mul_result;
                        ovf_reg  <= ovf_reg | mul_overflow;
                    end
                end
                WRITE: begin
                    i_reg   <= i_reg + WORD_SIZE'(1);
                    ovf_reg <= ovf_reg | add_ovf;
                end
                default: begin
                end
            endcase
        end
    end

    // dx is forwarded straight from the read port into the multiplier
    // request, so it never needs a holding register of its own.
    always_comb begin
        state_nx    = state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mul_start   = 1'b0;
        mul_op1     = '0;
        mul_op2     = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (n == '0) ? DONE : RD_X;
                end
            end
            RD_X: begin
                busy        = 1'b1;
                mem_rd_addr = x_base_reg + idx;
                state_nx    = RD_DX;
            end
            RD_DX: begin
                busy        = 1'b1;
                mem_rd_addr = dx_base_reg + idx;
                state_nx    = MUL_REQ;
            end
            MUL_REQ: begin
                busy      = 1'b1;
                mul_start = 1'b1;
                mul_op1   = h_reg;
                mul_op2   = mem_rd_data;
                state_nx  = MUL_WAIT;
            end
            MUL_WAIT: begin
                busy = 1'b1;
                if (mul_done) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_wr_addr = out_base_reg + idx;
                mem_wr_data = sum;
                state_nx    = last ? DONE : RD_X;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // A reset cycle must not leak a write, request or done pulse.
        if (!rst) begin
            busy        = 1'b0;
            done        = 1'b0;
            mem_rd_addr = '0;
            mem_wr_en   = 1'b0;
            mem_wr_addr = '0;
            mem_wr_data = '0;
            mul_start   = 1'b0;
            mul_op1     = '0;
            mul_op2     = '0;
        end
    end

endmodule

// File: tb/tb_euler_update_stage.sv
// Self-checking bench for euler_update_stage: scratch memory and
// multiplier models plus a sequential reference of the whole pass.
module tb_euler_update_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] n;
    logic [15:0] step;
    logic [3:0]  x_base;
    logic [3:0]  dx_base;
    logic [3:0]  out_base;
    logic [3:0]  mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic        mul_start;
    logic [15:0] mul_op1;
    logic [15:0] mul_op2;
    logic [15:0] mul_result = '0;
    logic        mul_done = 1'b0;
    logic        mul_overflow = 1'b0;
    logic        busy;
    logic        done;
    logic        overflow;

    logic [15:0] mem [16];
    logic [15:0] img [16];
    logic        load = 1'b0;
    int          lat = 1;
    int          force_at = -1;
    int          wr_cnt = 0;
    int          mul_cnt = 0;
    int          mcnt = 0;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    euler_update_stage dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .n            (n),
        .step         (step),
        .x_base       (x_base),
        .dx_base      (dx_base),
        .out_base     (out_base),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mul_start    (mul_start),
        .mul_op1      (mul_op1),
        .mul_op2      (mul_op2),
        .mul_result   (mul_result),
        .mul_done     (mul_done),
        .mul_overflow (mul_overflow),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    // Scaled signed product h*dx / 2^7, flagged when it leaves 16 bits.
    function automatic void mul_ref(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output bit ovf);
        longint p;
        p   = (longint'($signed(a)) * longint'($signed(b))) >>> 7;
        ovf = (p > 32767) || (p < -32768);
        r   = 16'(p);
    endfunction

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) mem[i] <= img[i];
        end else if (mem_wr_en) begin
            mem[mem_wr_addr] <= mem_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        mem_rd_data <= mem[mem_rd_addr];
    end

    always @(posedge clk) begin
        logic [15:0] r;
        bit          o;
        mul_done <= 1'b0;
        if (mul_start) begin
            mul_ref(mul_op1, mul_op2, r, o);
            mul_result   <= r;
            mul_overflow <= o || (mul_cnt == force_at);
            mul_cnt      <= mul_cnt + 1;
            if (lat <= 1) mul_done <= 1'b1;
            else mcnt <= lat - 1;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) mul_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic load_img();
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic run_pass(input string tag, input int nn, input logic [15:0] h,
                            input logic [3:0] xb, input logic [3:0] db,
                            input logic [3:0] ob, input int l, input int fidx,
                            input bit poke);
        logic [15:0] rm [16];
        logic [15:0] xv, dv, p, s;
        logic [3:0]  a;
        bit          po, ao, eo;
        int          t, dk, ek, w0, m0;
        rm = img;
        eo = 1'b0;
        for (int i = 0; i < nn; i++) begin
            a  = xb + 4'(i);
            xv = rm[a];
            a  = db + 4'(i);
            dv = rm[a];
            mul_ref(h, dv, p, po);
            t  = int'($signed(xv)) + int'($signed(p));
            ao = (t > 32767) || (t < -32768);
`ifdef SATURATE_EN
            s = (t > 32767) ? 16'h7fff : (t < -32768) ? 16'h8000 : 16'(t);
`else
            s = 16'(t);
`endif
            eo = eo | po | ao | (i == fidx);
            a  = ob + 4'(i);
            rm[a] = s;
        end
        load_img();
        lat      = l;
        w0       = wr_cnt;
        m0       = mul_cnt;
        force_at = (fidx < 0) ? -1 : m0 + fidx;
        @(negedge clk);
        start    = 1'b1;
        n        = 16'(nn);
        step     = h;
        x_base   = xb;
        dx_base  = db;
        out_base = ob;
        ek = nn * (4 + l) + 1;
        dk = -1;
        for (int k = 1; k <= ek + 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start  = 1'b0;
                n      = 16'hffff;
                step   = 16'(~h);
                x_base = ~xb;
                chk({tag, ".busy"}, 32'(busy), 32'(nn != 0));
            end
            if (poke && k == 3) start = 1'b1;
            if (poke && k == 4) start = 1'b0;
            if (done) begin
                dk = k;
                break;
            end
        end
        chk({tag, ".done_at"}, dk, ek);
        chk({tag, ".ovf_done"}, 32'(overflow), 32'(eo));
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(done), 0);
        chk({tag, ".ovf_after"}, 32'(overflow), 32'(eo));
        chk({tag, ".writes"}, wr_cnt - w0, nn);
        chk({tag, ".mul_reqs"}, mul_cnt - m0, nn);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s.mem%0d", tag, i), mem[i], rm[i]);
        force_at = -1;
    endtask

    initial begin
        int  w0, m0;
        bit  saw;
        rst      = 1'b0;
        start    = 1'b0;
        n        = '0;
        step     = '0;
        x_base   = '0;
        dx_base  = '0;
        out_base = '0;
        for (int i = 0; i < 16; i++) img[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst.ctrl", {busy, done, overflow, mem_wr_en, mul_start}, 0);
        chk("rst.addr", {mem_rd_addr, mem_wr_addr}, 0);
        chk("rst.wdata", mem_wr_data, 0);
        chk("rst.ops", {mul_op1, mul_op2}, 0);
        rst = 1'b1;

        img[0] = 16'd128;
        img[4] = 16'd256;
        run_pass("t1", 1, 16'd64, 4'd0, 4'd4, 4'd8, 1, -1, 1'b1);
        chk("t1.out", mem[8], 16'd256);

        for (int i = 0; i < 16; i++) img[i] = '0;
        img[8]  = 16'd1;
        img[9]  = 16'd2;
        img[10] = 16'd3;
        img[12] = 16'd10;
        img[13] = 16'd20;
        img[14] = 16'd30;
        run_pass("t2", 3, 16'd128, 4'd8, 4'd12, 4'd8, 2, -1, 1'b0);
        chk("t2.out", {mem[8], mem[9]}, {16'd11, 16'd22});
        chk("t2.out2", mem[10], 16'd33);

        run_pass("t3", 0, 16'd128, 4'd0, 4'd1, 4'd2, 1, -1, 1'b0);

        for (int i = 0; i < 16; i++) img[i] = '0;
        img[0] = 16'h7f00;
        img[1] = 16'h0200;
        run_pass("t4", 1, 16'd128, 4'd0, 4'd1, 4'd2, 1, -1, 1'b0);
`ifdef SATURATE_EN
        chk("t4.out", mem[2], 16'h7fff);
`else
        chk("t4.out", mem[2], 16'h8100);
`endif
        chk("t4.ovf", 32'(overflow), 1);

        for (int i = 0; i < 16; i++) img[i] = 16'($urandom_range(0, 255));
        run_pass("t5", 2, 16'd32, 4'd0, 4'd2, 4'd4, 2, 0, 1'b0);
        chk("t5.ovf", 32'(overflow), 1);

        for (int i = 0; i < 16; i++) img[i] = 16'($urandom_range(0, 255));
        load_img();
        lat = 3;
        w0  = wr_cnt;
        m0  = mul_cnt;
        @(negedge clk);
        start    = 1'b1;
        n        = 16'd2;
        step     = 16'd128;
        x_base   = 4'd0;
        dx_base  = 4'd4;
        out_base = 4'd8;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        chk("t6.busy_mid", 32'(busy), 1);
        chk("t6.mul_reqs", mul_cnt - m0, 2);
        rst = 1'b0;
        @(negedge clk);
        chk("t6.ctrl", {busy, done, overflow, mem_wr_en, mul_start}, 0);
        chk("t6.addr", {mem_rd_addr, mem_wr_addr}, 0);
        chk("t6.ops", {mul_op1, mul_op2}, 0);
        rst = 1'b1;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || mem_wr_en) saw = 1'b1;
        end
        chk("t6.quiet", 32'(saw), 0);
        chk("t6.writes", wr_cnt - w0, 1);
        run_pass("t6.after", 2, 16'd128, 4'd0, 4'd4, 4'd8, 3, -1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int fi;
            for (int i = 0; i < 16; i++) img[i] = 16'($urandom);
            fi = ($urandom_range(0, 3) == 0) ? 0 : -1;
            run_pass($sformatf("rnd%0d", r), int'($urandom_range(1, 5)),
                     16'($urandom_range(0, 511) - 256),
                     4'($urandom), 4'($urandom), 4'($urandom),
                     int'($urandom_range(1, 4)), fi, 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
